// File: rtl/debounce_pkg.sv
// debounce_pkg: shared helpers for the debounce block.
//   cnt_width(cnt_max) - bit width needed for a counter holding 0..cnt_max.
package debounce_pkg;

  function automatic int cnt_width(input int cnt_max);
    return (cnt_max < 1) ? 1 : $clog2(cnt_max + 1);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one debounce channel.
// Two-flop synchroniser, stability counter, four-state filter FSM and
// registered one-cycle edge pulses.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   din    - raw asynchronous input
//   dout   - debounced level (registered)
//   rise   - one-cycle pulse on accepted 0->1 (registered)
//   fall   - one-cycle pulse on accepted 1->0 (registered)
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int CNT_MAX = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(CNT_MAX);
  localparam logic [CW-1:0] CntLast = CW'(CNT_MAX - 1);

  typedef enum logic [1:0] {
    SLow      = 2'd0,
    SRisePend = 2'd1,
    SHigh     = 2'd2,
    SFallPend = 2'd3
  } state_e;

  logic          sync1_q, s_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dout_q, dout_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      state_q <= SLow;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      s_q     <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      SLow: begin
        if (s_q) begin
          if (CNT_MAX == 1) begin
            // A single stable cycle is enough: accept immediately.
            state_d = SHigh;
            dout_d  = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = SRisePend;
            cnt_d   = CW'(1);
          end
        end
      end
      SRisePend: begin
        if (!s_q) begin
          state_d = SLow;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = SHigh;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHigh: begin
        if (!s_q) begin
          if (CNT_MAX == 1) begin
            state_d = SLow;
            dout_d  = 1'b0;
            fall_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = SFallPend;
            cnt_d   = CW'(1);
          end
        end
      end
      SFallPend: begin
        if (s_q) begin
          state_d = SHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = SLow;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = SLow;
        cnt_d   = '0;
      end
    endcase
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/debounce.sv
// debounce: multi-channel push-button / switch input conditioner.
// Each bit is synchronised and filtered independently by a debounce_ch.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   din    - raw asynchronous inputs [WIDTH-1:0]
//   dout   - debounced levels [WIDTH-1:0] (registered)
//   rise   - one-cycle pulse per accepted 0->1 [WIDTH-1:0] (registered)
//   fall   - one-cycle pulse per accepted 1->0 [WIDTH-1:0] (registered)
module debounce #(
  parameter int WIDTH   = 2,
  parameter int CNT_MAX = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  if (WIDTH < 1 || CNT_MAX < 1) begin : g_param_err
    $error("debounce: WIDTH and CNT_MAX must both be >= 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_ch #(
      .CNT_MAX(CNT_MAX)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (din[i]),
      .dout (dout[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

endmodule
